// File: rtl/uart_pkg.sv
// uart_pkg: baud constants, bsp_set encodings, receiver states and divisor lookup shared by the UART blocks
package uart_pkg;

    localparam logic [15:0] BPS_9600   = 16'd5207;
    localparam logic [15:0] BPS_19200  = 16'd2603;
    localparam logic [15:0] BPS_38400  = 16'd1301;
    localparam logic [15:0] BPS_57600  = 16'd867;
    localparam logic [15:0] BPS_115200 = 16'd433;

    localparam logic [2:0] BSP_9600   = 3'd0;
    localparam logic [2:0] BSP_19200  = 3'd1;
    localparam logic [2:0] BSP_38400  = 3'd2;
    localparam logic [2:0] BSP_57600  = 3'd3;
    localparam logic [2:0] BSP_115200 = 3'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Bit period minus one; unknown encodings fall back to 9600
    function automatic logic [15:0] bps_cnt_of(input logic [2:0] bsp);
        return (bsp == BSP_19200)  ? BPS_19200  :
               (bsp == BSP_38400)  ? BPS_38400  :
               (bsp == BSP_57600)  ? BPS_57600  :
               (bsp == BSP_115200) ? BPS_115200 : BPS_9600;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rxd synchroniser, falling-edge detect and sample value (2-of-3 majority under UART_RX_MAJORITY_EN)
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rx_fall,
    output logic rx_smp
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_d;

    assign rx_s    = sync[SYNC_STAGES-1];
    assign rx_fall = rx_d & ~rx_s;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync <= '1;
            rx_d <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], uart_rxd};
            rx_d <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_dd;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            rx_dd <= 1'b1;
        else
            rx_dd <= rx_d;
    end

    // History window is {rx_dd, rx_d, rx_s}, so the sample point stays where it is without the filter
    assign rx_smp = (rx_s & rx_d) | (rx_s & rx_dd) | (rx_d & rx_dd);
`else
    assign rx_smp = rx_s;
`endif

endmodule

// File: rtl/uart_bsp_recv.sv
// uart_bsp_recv: 8N1 UART receiver with bsp_set-selected baud; UART_RX_MAJORITY_EN enables majority sampling
module uart_bsp_recv
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    input  logic [2:0] bsp_set,
    output logic [7:0] uart_dout,
    output logic       uart_done,
    output logic       rx_flag,
    output logic       frame_err
);

    rx_state_t   state;
    logic [15:0] clk_cnt;
    logic [15:0] bps_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        rx_fall;
    logic        rx_smp;
    logic        bit_end;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rx_fall   (rx_fall),
        .rx_smp    (rx_smp)
    );

    assign bit_end = (clk_cnt == bps_cnt);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bps_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_dout <= '0;
            uart_done <= 1'b0;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (rx_fall) begin
                    state   <= START;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    bps_cnt <= bps_cnt_of(bsp_set);
                    rx_flag <= 1'b1;
                end
                // A start bit still high at its midpoint was a glitch
                START: if (clk_cnt == (bps_cnt >> 1)) begin
                    clk_cnt <= '0;
                    state   <= rx_smp ? IDLE : DATA;
                    rx_flag <= ~rx_smp;
                end else begin
                    clk_cnt <= clk_cnt + 16'd1;
                end
                DATA: if (bit_end) begin
                    clk_cnt   <= '0;
                    shift_reg <= {rx_smp, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= STOP;
                end else begin
                    clk_cnt <= clk_cnt + 16'd1;
                end
                STOP: if (bit_end) begin
                    clk_cnt   <= '0;
                    state     <= IDLE;
                    rx_flag   <= 1'b0;
                    uart_done <= rx_smp;
                    frame_err <= ~rx_smp;
                    if (rx_smp)
                        uart_dout <= shift_reg;
                end else begin
                    clk_cnt <= clk_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bsp_recv.sv
// tb_uart_bsp_recv: directed and random frames checked against an expected-byte model derived from 8N1 framing rules
module tb_uart_bsp_recv;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [2:0] bsp_set = 3'd4;
    logic [7:0] uart_dout;
    logic       uart_done;
    logic       rx_flag;
    logic       frame_err;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int         ferr_cnt = 0;
    int         ferr_exp = 0;
    int         flag_cyc = 0;
    bit         both_seen = 1'b0;
    int         rd = 0;
    logic [7:0] last_good = 8'h00;

    always #10 sys_clk = ~sys_clk;

    uart_bsp_recv dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .bsp_set   (bsp_set),
        .uart_dout (uart_dout),
        .uart_done (uart_done),
        .rx_flag   (rx_flag),
        .frame_err (frame_err)
    );

    always @(negedge sys_clk) begin
        if (uart_done) rxq.push_back(uart_dout);
        if (frame_err) ferr_cnt++;
        if (rx_flag) flag_cyc++;
        if (uart_done && frame_err) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit period in clocks, rounded from 50 MHz / baud
    function automatic int period(input logic [2:0] b);
        int baud;
        baud = (b == 3'd1) ? 19200 : (b == 3'd2) ? 38400 : (b == 3'd3) ? 57600 :
               (b == 3'd4) ? 115200 : 9600;
        return (50_000_000 + baud / 2) / baud;
    endfunction

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            uart_rxd = v;
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int p, input logic stop, input bit glitch,
                        input logic [2:0] mid_bsp);
        hold(1'b0, p);
        bsp_set = mid_bsp;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < p; c++) begin
                uart_rxd = (glitch && c == p / 2) ? ~d[k] : d[k];
                @(posedge sys_clk);
                #1;
            end
        hold(stop, p);
    endtask

    task automatic expect_good(input logic [7:0] d);
        expq.push_back(d);
        last_good = d;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, rxq.size(), expq.size());
        for (int i = rd; i < expq.size() && i < rxq.size(); i++)
            chk({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, expq[i]});
        rd = expq.size();
        chk({tag, "_ferr"}, ferr_cnt, ferr_exp);
        chk({tag, "_dout"}, {24'd0, uart_dout}, {24'd0, last_good});
        chk({tag, "_flag_idle"}, {31'd0, rx_flag}, 32'd0);
    endtask

    initial begin
        int p;
        int f0;
        logic [7:0] d;
        logic [2:0] b;

        hold(1'b1, 5);
        chk("rst_dout", {24'd0, uart_dout}, 32'd0);
        chk("rst_done", {31'd0, uart_done}, 32'd0);
        chk("rst_flag", {31'd0, rx_flag}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        sys_rst_n = 1'b1;
        hold(1'b1, 10);

        p = period(3'd4);
        bsp_set = 3'd4;
        f0 = flag_cyc;
        send(8'hA5, p, 1'b1, 1'b0, 3'd4);
        expect_good(8'hA5);
        hold(1'b1, 20);
        chk("a5_flag_len", {31'd0, (flag_cyc - f0 >= 9 * p) && (flag_cyc - f0 <= 10 * p)}, 32'd1);
        compare("a5");

        send(8'h00, p, 1'b1, 1'b0, 3'd4);
        send(8'hFF, p, 1'b1, 1'b0, 3'd4);
        expect_good(8'h00);
        expect_good(8'hFF);
        hold(1'b1, 20);
        compare("b2b");

        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            b = 3'($urandom_range(0, 7));
            bsp_set = 3'd4;
            send(d, p, 1'b1, 1'b0, b);
            expect_good(d);
            bsp_set = 3'd4;
            hold(1'b1, 20);
            compare("rand");
        end

        bsp_set = 3'd0;
        f0 = flag_cyc;
        hold(1'b0, 100);
        hold(1'b1, 3000);
        chk("glitch_flag_len", {31'd0, (flag_cyc - f0 >= 2600) && (flag_cyc - f0 <= 2610)}, 32'd1);
        compare("glitch");

        bsp_set = 3'd2;
        p = period(3'd2);
        send(8'h3C, p, 1'b0, 1'b0, 3'd2);
        ferr_exp++;
        hold(1'b0, 10 * p);
        compare("ferr_break");
        hold(1'b1, 2 * p);
        bsp_set = 3'd4;
        p = period(3'd4);
        send(8'h96, p, 1'b1, 1'b0, 3'd4);
        expect_good(8'h96);
        hold(1'b1, 20);
        compare("after_break");

        hold(1'b0, p);
        for (int k = 0; k < 4; k++) hold(k[0], p);
        hold(1'b0, p / 2);
        sys_rst_n = 1'b0;
        hold(1'b1, 3);
        chk("midrst_flag", {31'd0, rx_flag}, 32'd0);
        chk("midrst_dout", {24'd0, uart_dout}, 32'd0);
        last_good = 8'h00;
        sys_rst_n = 1'b1;
        hold(1'b1, 20);
        send(8'h5A, p, 1'b1, 1'b0, 3'd4);
        expect_good(8'h5A);
        hold(1'b1, 20);
        compare("midrst");

        bsp_set = 3'd3;
        p = period(3'd3);
        send(8'h81, p, 1'b1, 1'b1, 3'd3);
`ifdef UART_RX_MAJORITY_EN
        expect_good(8'h81);
`else
        expect_good(8'h7E);
`endif
        hold(1'b1, 20);
        compare("mid_glitch");

        chk("done_ferr_exclusive", {31'd0, both_seen}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
